scarv_ccx_mmio_timer: RTL and testbench
=======================================

// Module: scarv_ccx_mmio_timer
// PURPOSE
//  Memory-mapped machine timer responder on the CCX MMIO port (scarv_ccx_memif REQ side of router).
//  Holds 64-bit mtime, mtimecmp, control and prescale registers; answers CPU loads/stores with 1-cycle response.
//  Raises a registered timer interrupt when mtime >= mtimecmp and interrupts are enabled.
// PARAMETERS
//  AW        32            address width of the memif
//  DW        32            data width of the memif; only 32 supported
//  PSC_W     16            width of prescale register and prescale counter
//  CMP_RESET 64'hFFFF_FFFF_FFFF_FFFF  reset value of mtimecmp
// PORTS
//  g_clk            input   1      clock
//  g_resetn         input   1      synchronous active-low reset
//  if_mmio.req      input   1      request valid
//  if_mmio.gnt      output  1      request accepted
//  if_mmio.wen      input   1      1 = write, 0 = read
//  if_mmio.strb     input   4      byte write strobes
//  if_mmio.addr     input   AW     byte address; only addr[7:0] decoded
//  if_mmio.wdata    input   DW     write data
//  if_mmio.rdata    output  DW     read data, valid cycle after accept
//  if_mmio.error    output  1      bus error, valid cycle after accept
//  timer_interrupt  output  1      level machine timer interrupt
// BEHAVIOUR
//  Register map (offset = addr[7:0]): 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 CMP_LO, 0x0C CMP_HI,
//   0x10 CTRL {bit1 IE, bit0 EN; other bits RAZ/WI}, 0x14 PSC (low PSC_W bits, rest RAZ/WI).
//  Reset values: mtime=0, mtimecmp=CMP_RESET, CTRL=2'b01, PSC=0, psc_cnt=0, rdata=0, error=0, timer_interrupt=0.
//  Handshake: gnt tied 1; accept = req && gnt. rdata/error registered from accept cycle, driven next cycle only.
//  Cycle after a non-accept cycle: rdata=0, error=0 (no stale data).
//  Reads: rdata = selected register; writes: rdata=0.
//  Error: addr[1:0]!=0 or offset not in map -> error=1, rdata=0, no register state change.
//  Writes honour strb per byte; strb=0 write is legal no-op with error=0.
//  Counting: when EN=1, psc_cnt increments each cycle; when psc_cnt==PSC, psc_cnt<=0 and mtime<=mtime+1.
//   PSC=0 -> mtime increments every cycle. EN=0 freezes mtime and psc_cnt.
//  mtime is a 64-bit counter; 0xFFFF_FFFF_FFFF_FFFF + 1 wraps to 0; carry lo->hi in same cycle.
//  Simultaneous write and tick: CPU write wins for written bytes; unwritten bytes of the 64-bit value
//   take the incremented value (write applied after increment).
//  Write to PSC or EN also clears psc_cnt to 0.
//  timer_interrupt <= IE && (mtime >= mtimecmp), unsigned 64-bit compare of current register values;
//   one-cycle latency from any mtime/mtimecmp/CTRL update. Level; cleared only by raising CMP or clearing IE.
//  Reset mid-transaction: accepted request discarded; cycle after reset deassert rdata=0, error=0.
//  No internal states beyond registers; no backpressure; back-to-back accepts every cycle supported.
// TESTING
//  Reset, read 0x00/0x04/0x08/0x0C -> 0x0000_0000, 0, 0xFFFF_FFFF, 0xFFFF_FFFF; error=0 each.
//  Write CMP_LO=0x20, CMP_HI=0, CTRL=0x3, PSC=0 -> timer_interrupt rises 1 cycle after mtime reaches 0x20.
//  Write MTIME_LO=0xFFFF_FFFE, MTIME_HI=0xFFFF_FFFF, EN=1 -> 2 ticks later mtime=0, HI reads 0.
//  PSC=3 with EN=1 -> mtime increments exactly once every 4 cycles over 40 cycles (10 increments).
//  Read 0x18, read 0x02, write 0x40 -> error=1, rdata=0, registers unchanged.
//  Write MTIME_LO strb=4'b0001 wdata=0xAB coincident with tick from 0x0000_01FF -> MTIME_LO=0x0000_02AB.

Source files
------------

// File: rtl/scarv_ccx_mmio_timer_if.sv
`default_nettype none
//==============================================================================
// scarv_ccx_mmio_timer_if : CCX memif request/response bundle for MMIO responders
// Revision : 1.0
//==============================================================================
interface scarv_ccx_mmio_timer_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          req;
   logic          gnt;
   logic          wen;
   logic [3:0]    strb;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;
   logic          error;

   modport master (
      output req, wen, strb, addr, wdata,
      input  gnt, rdata, error
   );

   modport slave (
      input  req, wen, strb, addr, wdata,
      output gnt, rdata, error
   );
endinterface
`default_nettype wire

// File: rtl/scarv_ccx_mmio_timer.sv
`default_nettype none
//==============================================================================
// scarv_ccx_mmio_timer : memory-mapped 64-bit machine timer with prescaler and
//                        registered compare interrupt, 1-cycle MMIO response.
// Revision : 1.0
//==============================================================================
module scarv_ccx_mmio_timer #(
   parameter int          AW        = 32,
   parameter int          DW        = 32,
   parameter int          PSC_W     = 16,
   parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
   input  logic                      g_clk,
   input  logic                      g_resetn,
   scarv_ccx_mmio_timer_if.slave     if_mmio,
   output logic                      timer_interrupt
);

   localparam logic [7:0] OFF_MTIME_LO = 8'h00;
   localparam logic [7:0] OFF_MTIME_HI = 8'h04;
   localparam logic [7:0] OFF_CMP_LO   = 8'h08;
   localparam logic [7:0] OFF_CMP_HI   = 8'h0C;
   localparam logic [7:0] OFF_CTRL     = 8'h10;
   localparam logic [7:0] OFF_PSC      = 8'h14;

   // Byte lanes of the PSC register that actually hold prescale bits.
   localparam logic [3:0] PSC_STRB = (PSC_W > 24) ? 4'hF :
                                     (PSC_W > 16) ? 4'h7 :
                                     (PSC_W > 8)  ? 4'h3 : 4'h1;

   logic [63:0]      mtime_q,   mtime_d;
   logic [63:0]      cmp_q,     cmp_d;
   logic [1:0]       ctrl_q,    ctrl_d;
   logic [PSC_W-1:0] psc_q,     psc_d;
   logic [PSC_W-1:0] psc_cnt_q, psc_cnt_d;
   logic [DW-1:0]    rdata_q,   rdata_d;
   logic             error_q,   error_d;
   logic             irq_q,     irq_d;

   logic [7:0]       offset;
   logic             accept;
   logic             addr_ok;
   logic             wr;
   logic             tick;
   logic [63:0]      mtime_inc;
   logic [DW-1:0]    rd_sel;
   logic [DW-1:0]    wr_old;
   logic [DW-1:0]    wr_merged;
   logic             unused_addr_hi;

   assign if_mmio.gnt     = 1'b1;
   assign if_mmio.rdata   = rdata_q;
   assign if_mmio.error   = error_q;
   assign timer_interrupt = irq_q;

   assign accept         = if_mmio.req && if_mmio.gnt;
   assign offset         = if_mmio.addr[7:0];
   assign addr_ok        = (offset[1:0] == 2'b00) && (offset <= OFF_PSC);
   assign wr             = accept && if_mmio.wen && addr_ok;
   assign unused_addr_hi = ^if_mmio.addr[AW-1:8];

   assign tick      = ctrl_q[0] && (psc_cnt_q == psc_q);
   assign mtime_inc = mtime_q + {63'd0, tick};

   // Writes merge onto the post-increment value so unwritten bytes still tick.
   always_comb begin
      rd_sel = '0;
      wr_old = '0;
      case (offset)
         OFF_MTIME_LO: begin rd_sel = mtime_q[31:0];  wr_old = mtime_inc[31:0];  end
         OFF_MTIME_HI: begin rd_sel = mtime_q[63:32]; wr_old = mtime_inc[63:32]; end
         OFF_CMP_LO:   begin rd_sel = cmp_q[31:0];    wr_old = cmp_q[31:0];      end
         OFF_CMP_HI:   begin rd_sel = cmp_q[63:32];   wr_old = cmp_q[63:32];     end
         OFF_CTRL:     begin rd_sel = {30'd0, ctrl_q}; wr_old = {30'd0, ctrl_q}; end
         OFF_PSC: begin
            rd_sel = DW'(psc_q);
            wr_old = DW'(psc_q);
         end
         default: ;
      endcase
   end

   always_comb begin
      wr_merged = wr_old;
      for (int b = 0; b < 4; b++) begin
         if (if_mmio.strb[b]) wr_merged[8*b +: 8] = if_mmio.wdata[8*b +: 8];
      end
   end

   always_comb begin
      mtime_d   = mtime_inc;
      cmp_d     = cmp_q;
      ctrl_d    = ctrl_q;
      psc_d     = psc_q;
      psc_cnt_d = psc_cnt_q;
      if (ctrl_q[0]) psc_cnt_d = tick ? '0 : psc_cnt_q + PSC_W'(1);

      if (wr) begin
         case (offset)
            OFF_MTIME_LO: mtime_d[31:0]  = wr_merged;
            OFF_MTIME_HI: mtime_d[63:32] = wr_merged;
            OFF_CMP_LO:   cmp_d[31:0]    = wr_merged;
            OFF_CMP_HI:   cmp_d[63:32]   = wr_merged;
            OFF_CTRL: begin
               ctrl_d = wr_merged[1:0];
               if (if_mmio.strb[0]) psc_cnt_d = '0;
            end
            OFF_PSC: begin
               psc_d = wr_merged[PSC_W-1:0];
               if (|(if_mmio.strb & PSC_STRB)) psc_cnt_d = '0;
            end
            default: ;
         endcase
      end

      rdata_d = (accept && !if_mmio.wen && addr_ok) ? rd_sel : '0;
      error_d = accept && !addr_ok;
      irq_d   = ctrl_q[1] && (mtime_q >= cmp_q);
   end

   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         mtime_q   <= '0;
         cmp_q     <= CMP_RESET;
         ctrl_q    <= 2'b01;
         psc_q     <= '0;
         psc_cnt_q <= '0;
         rdata_q   <= '0;
         error_q   <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         mtime_q   <= mtime_d;
         cmp_q     <= cmp_d;
         ctrl_q    <= ctrl_d;
         psc_q     <= psc_d;
         psc_cnt_q <= psc_cnt_d;
         rdata_q   <= rdata_d;
         error_q   <= error_d;
         irq_q     <= irq_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_scarv_ccx_mmio_timer.sv
`default_nettype none
//==============================================================================
// tb_scarv_ccx_mmio_timer : scoreboard bench with a behavioural timer model.
// Revision : 1.0
//==============================================================================
module tb_scarv_ccx_mmio_timer;

   logic g_clk = 1'b0;
   logic g_resetn;
   logic timer_interrupt;

   always #5 g_clk = ~g_clk;

   scarv_ccx_mmio_timer_if #(.AW(32), .DW(32)) mmio ();

   scarv_ccx_mmio_timer #(
      .AW(32), .DW(32), .PSC_W(16), .CMP_RESET(64'hFFFF_FFFF_FFFF_FFFF)
   ) dut (
      .g_clk           (g_clk),
      .g_resetn        (g_resetn),
      .if_mmio         (mmio),
      .timer_interrupt (timer_interrupt)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        irq;
      string       tag;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   bit   stim_done = 0;

   // Architectural view of the timer
   logic [63:0] m_mtime, m_cmp;
   logic [1:0]  m_ctrl;
   logic [15:0] m_psc, m_cnt;

   task automatic model_reset();
      m_mtime = 64'd0;
      m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
      m_ctrl  = 2'b01;
      m_psc   = 16'd0;
      m_cnt   = 16'd0;
   endtask

   function automatic bit m_err(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a[7:0] > 8'h14);
   endfunction

   function automatic logic [31:0] m_read(input logic [7:0] off);
      case (off)
         8'h00:   return m_mtime[31:0];
         8'h04:   return m_mtime[63:32];
         8'h08:   return m_cmp[31:0];
         8'h0C:   return m_cmp[63:32];
         8'h10:   return {30'd0, m_ctrl};
         8'h14:   return {16'd0, m_psc};
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   // One bus cycle: present inputs, predict the response, advance the model.
   task automatic cyc(input bit rn, input bit v, input bit w, input logic [3:0] s,
                      input logic [31:0] a, input logic [31:0] d,
                      input bit use_c, input logic [31:0] cval, input string tag);
      exp_t        e;
      bit          tk;
      logic [63:0] nt;
      logic [15:0] ncnt;
      logic [31:0] tmp;
      g_resetn   = rn;
      mmio.req   = v;
      mmio.wen   = w;
      mmio.strb  = s;
      mmio.addr  = a;
      mmio.wdata = d;
      e.tag = tag;
      if (!rn) begin
         e.rdata = 32'd0;
         e.err   = 1'b0;
         e.irq   = 1'b0;
         model_reset();
      end else begin
         e.err   = v && m_err(a);
         e.rdata = (v && !w && !e.err) ? m_read(a[7:0]) : 32'd0;
         if (use_c) e.rdata = cval;
         e.irq   = m_ctrl[1] && (m_mtime >= m_cmp);
         tk   = m_ctrl[0] && (m_cnt == m_psc);
         nt   = tk ? m_mtime + 64'd1 : m_mtime;
         ncnt = m_ctrl[0] ? (tk ? 16'd0 : m_cnt + 16'd1) : m_cnt;
         if (v && w && !e.err) begin
            case (a[7:0])
               8'h00: nt[31:0]     = merge(nt[31:0], d, s);
               8'h04: nt[63:32]    = merge(nt[63:32], d, s);
               8'h08: m_cmp[31:0]  = merge(m_cmp[31:0], d, s);
               8'h0C: m_cmp[63:32] = merge(m_cmp[63:32], d, s);
               8'h10: begin
                  tmp = merge({30'd0, m_ctrl}, d, s);
                  m_ctrl = tmp[1:0];
                  if (s[0]) ncnt = 16'd0;
               end
               8'h14: begin
                  tmp = merge({16'd0, m_psc}, d, s);
                  m_psc = tmp[15:0];
                  if (s[1:0] != 2'b00) ncnt = 16'd0;
               end
               default: ;
            endcase
         end
         m_mtime = nt;
         m_cnt   = ncnt;
      end
      @(posedge g_clk);
      q.push_back(e);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      cyc(1, 1, 1, s, a, d, 0, 32'd0, "write");
   endtask

   task automatic rd(input logic [31:0] a, input string tag);
      cyc(1, 1, 0, 4'h0, a, 32'd0, 0, 32'd0, tag);
   endtask

   task automatic rdc(input logic [31:0] a, input logic [31:0] val, input string tag);
      cyc(1, 1, 0, 4'h0, a, 32'd0, 1, val, tag);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 0, 4'h0, 32'd0, 32'd0, 0, 32'd0, "idle");
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s actual=%h required=%h", name, act, req);
   endtask

   // Monitor: every response cycle is matched against the oldest prediction.
   initial begin
      exp_t e;
      forever begin
         @(negedge g_clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk({e.tag, "/rdata"}, mmio.rdata, e.rdata);
            chk({e.tag, "/error"}, {31'd0, mmio.error}, {31'd0, e.err});
            chk({e.tag, "/irq"},   {31'd0, timer_interrupt}, {31'd0, e.irq});
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] a, d;
      int          pick;
      model_reset();
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 4'h0, 32'd0, 32'd0, 0, 32'd0, "reset");

      rdc(32'h00, 32'h0000_0000, "rst_mtime_lo");
      rdc(32'h04, 32'h0000_0000, "rst_mtime_hi");
      rdc(32'h08, 32'hFFFF_FFFF, "rst_cmp_lo");
      rdc(32'h0C, 32'hFFFF_FFFF, "rst_cmp_hi");
      rdc(32'h10, 32'h0000_0001, "rst_ctrl");
      rdc(32'h14, 32'h0000_0000, "rst_psc");

      // compare interrupt at mtime == 0x20
      wr(32'h10, 32'h0, 4'hF);
      wr(32'h00, 32'h0, 4'hF);
      wr(32'h04, 32'h0, 4'hF);
      wr(32'h08, 32'h20, 4'hF);
      wr(32'h0C, 32'h0, 4'hF);
      wr(32'h14, 32'h0, 4'hF);
      wr(32'h10, 32'h3, 4'hF);
      idle(36);
      wr(32'h0C, 32'h1, 4'hF);
      idle(2);
      wr(32'h0C, 32'h0, 4'hF);
      idle(2);
      wr(32'h10, 32'h1, 4'hF);
      idle(2);

      // 64-bit wrap
      wr(32'h10, 32'h0, 4'hF);
      wr(32'h00, 32'hFFFF_FFFE, 4'hF);
      wr(32'h04, 32'hFFFF_FFFF, 4'hF);
      wr(32'h10, 32'h1, 4'hF);
      idle(2);
      rdc(32'h00, 32'h0, "wrap_lo");
      rdc(32'h04, 32'h0, "wrap_hi");

      // prescale 3: 10 increments over 40 cycles
      wr(32'h10, 32'h0, 4'hF);
      wr(32'h00, 32'h0, 4'hF);
      wr(32'h04, 32'h0, 4'hF);
      wr(32'h14, 32'h3, 4'hF);
      wr(32'h10, 32'h1, 4'hF);
      idle(40);
      rdc(32'h00, 32'd10, "psc3_lo");

      // decode errors leave state untouched
      rd(32'h18, "err_rd18");
      rd(32'h02, "err_rd02");
      wr(32'h40, 32'hFFFF_FFFF, 4'hF);
      wr(32'h11, 32'h0, 4'hF);
      rdc(32'h14, 32'h3, "err_psc");
      rdc(32'h10, 32'h1, "err_ctrl");
      wr(32'h08, 32'hDEAD_BEEF, 4'h0);
      rd(32'h08, "strb0_cmp");
      rd(32'hABCD_0010, "hiaddr_ctrl");

      // partial write coincident with a tick
      wr(32'h10, 32'h0, 4'hF);
      wr(32'h00, 32'h1FF, 4'hF);
      wr(32'h04, 32'h0, 4'hF);
      wr(32'h14, 32'h0, 4'hF);
      wr(32'h10, 32'h1, 4'hF);
      wr(32'h00, 32'hAB, 4'b0001);
      rdc(32'h00, 32'h0000_02AB, "strb_tick_lo");

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         pick = $urandom_range(0, 9);
         case (pick)
            0, 1, 2, 3, 4, 5: a = 32'(pick * 4);
            6: a = {24'd0, 6'($urandom_range(6, 63)), 2'b00};
            7: a = {$urandom_range(0, 255)} | 32'h1;
            8: a = $urandom;
            default: a = {$urandom_range(1, 255), 8'(4 * $urandom_range(0, 5))};
         endcase
         d = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 64));
         cyc(1, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             4'($urandom), a, d, 0, 32'd0, "rand");
      end

      // reset in the middle of an accepted request
      cyc(0, 1, 0, 4'h0, 32'h08, 32'd0, 0, 32'd0, "mid_reset");
      rdc(32'h00, 32'h0, "post_rst_lo");
      rdc(32'h08, 32'hFFFF_FFFF, "post_rst_cmp");
      idle(2);

      @(negedge g_clk);
      @(negedge g_clk);
      #1;
      chk("drain", 32'(q.size()), 32'd0);
      stim_done = 1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
